// File: rtl/window3x3_gen_pkg.sv
// window3x3_gen_pkg: shared window geometry and FSM encoding for window3x3_gen
package window3x3_gen_pkg;
  localparam int NTAPS = 9;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;
endpackage

// File: rtl/window3x3_gen_line_buf.sv
// window3x3_gen_line_buf: DEPTH-deep circular delay line, read-before-write, storage not reset
//   clk, rst_n : clock, async active-low reset (pointer only)
//   we_i       : advance one slot (push d_i, present the value pushed DEPTH writes ago)
//   d_i, q_o   : write data, delayed read data
module window3x3_gen_line_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  assign q_o = mem_q[ptr_q];
  assign ptr_d = ptr_q == AW'(DEPTH - 1) ? '0 : ptr_q + AW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else if (we_i) ptr_q <= ptr_d;
  always_ff @(posedge clk)
    if (we_i) mem_q[ptr_q] <= d_i;
endmodule

// File: rtl/window3x3_gen.sv
// window3x3_gen: raster pixel stream to packed 3x3 neighbourhood windows (border windows dropped)
//   clk, rst_n          : clock, async active-low reset
//   enable              : global stall, 0 freezes all state and squashes win_valid/win_last
//   sof, pix_valid      : start of frame (qualified by pix_valid), pixel valid
//   pix_in              : raster-order pixel
//   win_out             : {p00,p01,p02,p10,p11,p12,p20,p21,p22}, p00 in the MSBs
//   win_valid, win_last : one-cycle window strobe, last window of the frame
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sof,
  input  logic                    pix_valid,
  input  logic [DATA_W-1:0]       pix_in,
  output logic [NTAPS*DATA_W-1:0] win_out,
  output logic                    win_valid,
  output logic                    win_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
  state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [0:2][0:2][DATA_W-1:0] tap_q, tap_d;
  logic [NTAPS*DATA_W-1:0] win_out_q;
  logic win_valid_q, win_last_q, win_valid_d, win_last_d;
  logic [DATA_W-1:0] lb0, lb1;
  logic acc, take, eol, eof;
  assign acc = enable & pix_valid;
  // IDLE pixels without sof never enter the pipeline
  assign take = acc & (state_q != IDLE | sof);
  // sof forces the current pixel to (0,0), aborting any frame in progress
  assign cur_col = sof ? '0 : col_q;
  assign cur_row = sof ? '0 : row_q;
  assign eol = cur_col == CMAX;
  assign eof = eol & (cur_row == RMAX);
  assign col_d = !take ? col_q : eol ? '0 : cur_col + CW'(1);
  assign row_d = !take ? row_q : !eol ? cur_row : cur_row == RMAX ? '0 : cur_row + RW'(1);
  window3x3_gen_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .we_i(take), .d_i(pix_in), .q_o(lb0)
  );
  window3x3_gen_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .we_i(take), .d_i(lb0), .q_o(lb1)
  );
  // shift left; the newest column is {two rows up, one row up, current}
  assign tap_d = {tap_q[0][1], tap_q[0][2], lb1,
                  tap_q[1][1], tap_q[1][2], lb0,
                  tap_q[2][1], tap_q[2][2], pix_in};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = !take ? state_q :
              sof ? FILL :
              state_q == FILL && cur_row == RW'(1) && eol ? RUN :
              state_q == RUN && eof ? IDLE : state_q;
  always_comb begin
    win_valid_d = take & ~sof & (state_q == RUN) & (col_q >= CW'(2));
    win_last_d = win_valid_d & eof;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      tap_q <= '0;
      win_out_q <= '0;
      win_valid_q <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q <= win_last_d;
      if (take) tap_q <= tap_d;
      if (win_valid_d) win_out_q <= tap_d;
    end
  assign win_out = win_out_q;
  assign win_valid = win_valid_q;
  assign win_last = win_last_q;
endmodule

// File: tb/tb_window3x3_gen.sv
// tb_window3x3_gen: randomized self-checking bench against a frame-buffer reference model
module tb_window3x3_gen;
  localparam int W = 4;
  localparam int H = 4;
  logic clk = 0, rst_n = 0, enable = 0, sof = 0, pix_valid = 0;
  logic [7:0] pix_in = 0;
  logic [71:0] win_out;
  logic win_valid, win_last;
  int nvec = 0, nerr = 0;
  bit ev, el;
  logic [71:0] ew;
  bit in_frame = 0;
  int n = 0;
  logic [7:0] img [W*H];
  always #5 clk = ~clk;
  window3x3_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sof(sof), .pix_valid(pix_valid),
    .pix_in(pix_in), .win_out(win_out), .win_valid(win_valid), .win_last(win_last)
  );
  // reference: store the frame in raster order, cut windows directly from it
  task automatic model(input bit a, input bit s, input logic [7:0] p);
    ev = 0; el = 0; ew = '0;
    if (!a) return;
    if (s) begin in_frame = 1; n = 0; end
    if (!in_frame) return;
    img[n] = p;
    if (n / W >= 2 && n % W >= 2) begin
      ev = 1;
      el = (n == W*H - 1);
      for (int dr = 2; dr >= 0; dr--)
        for (int dc = 2; dc >= 0; dc--) ew = {ew[63:0], img[n - dr*W - dc]};
    end
    n++;
    if (n == W*H) in_frame = 0;
  endtask
  task automatic step(input bit en, input bit s, input bit v, input logic [7:0] p);
    enable = en; sof = s; pix_valid = v; pix_in = p;
    @(posedge clk);
    model(en & v, s, p);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    step(1, 1, 1, 8'h55);
    ev = 0; el = 0; in_frame = 0;
    nvec++;
    if (win_valid !== 1'b0 || win_last !== 1'b0 || win_out !== 72'h0) begin
      nerr++;
      $display("FAIL reset: got v=%b l=%b w=%h, need all zero", win_valid, win_last, win_out);
    end
    rst_n = 1;
    step(1, 0, 0, 0);
  endtask
  task automatic test_full_frame();
    int seen = 0;
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, 1, 8'(i));
      seen += int'(win_valid);
      nvec++;
      if (win_valid !== ev || win_last !== el || (ev && win_out !== ew)) begin
        nerr++;
        $display("FAIL full_frame px%0d: got v=%b l=%b w=%h, exp v=%b l=%b w=%h", i, win_valid, win_last, win_out, ev, el, ew);
      end
      if (i == 10) begin
        nvec++;
        if (win_valid !== 1'b1 || win_out !== 72'h00_01_02_04_05_06_08_09_0a) begin
          nerr++;
          $display("FAIL first_window: got v=%b w=%h, exp v=1 w=00010204050608090a", win_valid, win_out);
        end
      end
    end
    nvec++;
    if (seen !== 4) begin nerr++; $display("FAIL full_frame_count: got %0d windows, exp 4", seen); end
    step(1, 0, 0, 0);
  endtask
  task automatic test_gaps();
    int seen = 0;
    for (int i = 0; i < 2*W*H; i++) begin
      step(1, i == 0, i % 2 == 0, 8'(i / 2));
      seen += int'(win_valid);
      nvec++;
      if (win_valid !== ev || win_last !== el || (ev && win_out !== ew)) begin
        nerr++;
        $display("FAIL gaps cyc%0d: got v=%b l=%b w=%h, exp v=%b l=%b w=%h", i, win_valid, win_last, win_out, ev, el, ew);
      end
    end
    nvec++;
    if (seen !== 4) begin nerr++; $display("FAIL gaps_count: got %0d windows, exp 4", seen); end
  endtask
  task automatic test_stall();
    int seen = 0;
    for (int i = 0; i < W*H + 5; i++) begin
      bit st = (i >= 11 && i < 16);
      int px = i < 11 ? i : st ? 11 : i - 5;
      step(!st, px == 0 && !st, 1, 8'(px));
      seen += int'(win_valid);
      nvec++;
      if (win_valid !== ev || win_last !== el || (ev && win_out !== ew)) begin
        nerr++;
        $display("FAIL stall cyc%0d: got v=%b l=%b w=%h, exp v=%b l=%b w=%h", i, win_valid, win_last, win_out, ev, el, ew);
      end
    end
    nvec++;
    if (seen !== 4) begin nerr++; $display("FAIL stall_count: got %0d windows, exp 4", seen); end
    step(1, 0, 0, 0);
  endtask
  task automatic test_restart();
    int seen = 0;
    for (int i = 0; i < 6 + W*H; i++) begin
      step(1, i == 0 || i == 6, 1, 8'($urandom));
      seen += int'(win_valid);
      nvec++;
      if (win_valid !== ev || win_last !== el || (ev && win_out !== ew)) begin
        nerr++;
        $display("FAIL restart cyc%0d: got v=%b l=%b w=%h, exp v=%b l=%b w=%h", i, win_valid, win_last, win_out, ev, el, ew);
      end
    end
    nvec++;
    if (seen !== 4) begin nerr++; $display("FAIL restart_count: got %0d windows, exp 4", seen); end
  endtask
  task automatic test_async_reset();
    int seen = 0;
    for (int i = 0; i <= 10; i++) step(1, i == 0, 1, 8'($urandom));
    nvec++;
    if (win_valid !== 1'b1 || win_out !== ew) begin
      nerr++;
      $display("FAIL pre_reset_window: got v=%b w=%h, exp v=1 w=%h", win_valid, win_out, ew);
    end
    #1 rst_n = 0;
    #1;
    nvec++;
    if (win_valid !== 1'b0 || win_last !== 1'b0 || win_out !== 72'h0) begin
      nerr++;
      $display("FAIL async_reset: got v=%b l=%b w=%h, need all zero", win_valid, win_last, win_out);
    end
    rst_n = 1;
    in_frame = 0;
    for (int i = 0; i < 6 + W*H; i++) begin
      step(1, i == 6, 1, 8'($urandom));
      seen += int'(win_valid);
      nvec++;
      if (win_valid !== ev || win_last !== el || (ev && win_out !== ew)) begin
        nerr++;
        $display("FAIL post_reset cyc%0d: got v=%b l=%b w=%h, exp v=%b l=%b w=%h", i, win_valid, win_last, win_out, ev, el, ew);
      end
    end
    nvec++;
    if (seen !== 4) begin nerr++; $display("FAIL post_reset_count: got %0d windows, exp 4", seen); end
  endtask
  task automatic test_back_to_back();
    int seen = 0, lasts = 0;
    for (int i = 0; i < 2*W*H; i++) begin
      step(1, i % (W*H) == 0, 1, 8'($urandom));
      seen += int'(win_valid);
      lasts += int'(win_last);
      nvec++;
      if (win_valid !== ev || win_last !== el || (ev && win_out !== ew)) begin
        nerr++;
        $display("FAIL b2b cyc%0d: got v=%b l=%b w=%h, exp v=%b l=%b w=%h", i, win_valid, win_last, win_out, ev, el, ew);
      end
    end
    nvec++;
    if (seen !== 8 || lasts !== 2) begin
      nerr++;
      $display("FAIL b2b_count: got %0d windows %0d lasts, exp 8 and 2", seen, lasts);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
      nvec++;
      if (win_valid !== ev || win_last !== el || (ev && win_out !== ew)) begin
        nerr++;
        $display("FAIL random cyc%0d: got v=%b l=%b w=%h, exp v=%b l=%b w=%h", i, win_valid, win_last, win_out, ev, el, ew);
      end
    end
  endtask
  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_stall();
    test_restart();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
